scan_index_sequencer: RTL
=========================

Name: scan_index_sequencer

Overview:
- Upstream stage of the 4-to-16 line decoder. Generates the 4-bit line index that the decoder expands into one-hot row strobes for a 16-line matrix (LED or keypad).
- Walks the enabled lines in ascending order. Holds each index for a programmable dwell time, then inserts a blanking gap against ghosting.
- Runs single-frame or continuous, and reports frame completion.

Parameters:
- DWELL_CYCLES, 4, cycles code_valid stays high per line; legal range 1..255.
- GAP_CYCLES, 1, blanking cycles after each dwell with code_valid low; legal range 0..255.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- stop  input  1  synchronous abort; returns to IDLE.
- continuous  input  1  1 = restart from the lowest enabled line after each frame; sampled at wrap.
- mask  input  16  line enables; bit i = line i is scanned.
- code  output  4  line index driven to the decoder input.
- code_valid  output  1  1 = decoder output may be enabled (row strobe active).
- frame_done  output  1  one-cycle pulse at frame end.
- busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset: state IDLE, code=0, code_valid=0, frame_done=0, busy=0, counter=0. rst has priority over every other input, including mid-dwell or mid-gap.
- All outputs are registered. The "edge" in each rule below is the edge that samples the condition.
- States: IDLE, SCAN, GAP.
- IDLE:
  - start=1 with mask!=0: at that edge go to SCAN, code=lowest set bit of mask, code_valid=1, counter reloaded.
  - start=1 with mask==0: ignored; outputs unchanged.
- SCAN:
  - code_valid=1 for exactly DWELL_CYCLES cycles.
  - At the last dwell cycle's edge, code_valid=0. Go to GAP if GAP_CYCLES>0; otherwise perform an advance at that edge.
- GAP:
  - code_valid=0 and code holds its value for exactly GAP_CYCLES cycles.
  - At the last gap cycle's edge, perform an advance.
- Advance:
  - mask is resampled at the advance edge. The next line is the lowest set bit above the current code.
  - Next line found: SCAN, code=that index, code_valid=1.
  - No higher bit (wrap), or mask==0: frame_done=1 for that one cycle.
    - continuous=1 and mask!=0: SCAN from the lowest set bit; the new code and code_valid=1 coincide with the frame_done cycle.
    - Otherwise: IDLE, code retains its last value, code_valid=0.
  - Line 15 is always a wrap point; the index never increments arithmetically past 15.
- stop=1 in SCAN or GAP: at that edge go to IDLE, code_valid=0, no frame_done. stop in IDLE has no effect.
- stop and start asserted together in IDLE: stop wins; remain IDLE.
- start in SCAN or GAP is ignored; no restart and no queuing.
- Glitch-free hand-off: code changes only on edges where code_valid is 0 before the edge, except for a zero-gap advance. In that case code and code_valid update on the same edge and the decoder sees the new index directly.
- Counter width is 8 bits. It loads DWELL_CYCLES-1 or GAP_CYCLES-1 on state entry and decrements to 0.
- Timing for one frame with mask=m, bit count k: k*(DWELL_CYCLES+GAP_CYCLES) cycles from the start edge to the frame_done cycle (inclusive of the last gap).

Test Plan:
- Defaults (4/1). rst, then start with mask=16'h0005, continuous=0 → code=0 valid 4 cycles; 1 gap; code=2 valid 4 cycles; 1 gap; frame_done pulses 1 cycle with busy→0; code stays 2.
- mask=16'hFFFF, continuous=1, start → codes 0,1,…,15 each valid 4 cycles with 1-cycle gaps. frame_done and code=0/code_valid=1 occur in the same cycle; a second frame follows identically.
- GAP_CYCLES=0, DWELL_CYCLES=1, mask=16'h8001, continuous=0 → code 0 then 15 on consecutive cycles, code_valid high both. frame_done on the next cycle, then IDLE.
- mask=16'h8001; during line 0's dwell, change mask to 16'h0010 → next code is 4, not 15. Set mask=0 before line 4's advance → frame_done pulse, IDLE.
- stop asserted in the 2nd dwell cycle of line 3 → next cycle IDLE, code_valid=0, no frame_done. start with mask=0 → no response. start pulsed while busy → sequence unchanged.
- rst asserted mid-gap → next cycle all outputs at reset values. start afterwards → scan restarts from the lowest enabled line.

Source files
------------

// File: rtl/scan_index_sequencer.sv
// Scan index sequencer: walks enabled matrix lines in ascending order,
// holding each 4-bit index for a dwell time followed by a blanking gap.
module scan_index_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int GAP_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic [15:0] mask,
  output logic [3:0]  code,
  output logic        code_valid,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GAP
  } state_t;

  localparam logic [7:0] DWELL_LD = 8'(DWELL_CYCLES - 1);
  localparam logic [7:0] GAP_LD =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_code;
  logic       r_valid;
  logic       r_done;

  state_t     w_state;
  logic [7:0] w_cnt;
  logic [3:0] w_code;
  logic       w_valid;
  logic       w_done;
  logic       w_adv;

  logic       w_low_hit;
  logic [3:0] w_low;
  logic       w_nxt_hit;
  logic [3:0] w_nxt;

  // Lowest set bit overall, and lowest set bit above the current line.
  always_comb begin
    w_low_hit = 1'b0;
    w_low     = 4'd0;
    w_nxt_hit = 1'b0;
    w_nxt     = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        w_low_hit = 1'b1;
        w_low     = 4'(i);
        if (4'(i) > r_code) begin
          w_nxt_hit = 1'b1;
          w_nxt     = 4'(i);
        end
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_code  = r_code;
    w_valid = r_valid;
    w_done  = 1'b0;
    w_adv   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !stop && w_low_hit) begin
          w_state = SCAN;
          w_code  = w_low;
          w_valid = 1'b1;
          w_cnt   = DWELL_LD;
        end
      end
      SCAN: begin
        if (stop) begin
          w_state = IDLE;
          w_valid = 1'b0;
          w_cnt   = 8'd0;
        end else if (r_cnt == 8'd0) begin
          w_valid = 1'b0;
          if (GAP_CYCLES > 0) begin
            w_state = GAP;
            w_cnt   = GAP_LD;
          end else begin
            w_adv = 1'b1;
          end
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      GAP: begin
        if (stop) begin
          w_state = IDLE;
          w_valid = 1'b0;
          w_cnt   = 8'd0;
        end else if (r_cnt == 8'd0) begin
          w_adv = 1'b1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state = IDLE;
        w_valid = 1'b0;
      end
    endcase

    // Wrap on no higher enabled line; line 15 always lands here.
    if (w_adv) begin
      if (w_nxt_hit) begin
        w_state = SCAN;
        w_code  = w_nxt;
        w_valid = 1'b1;
        w_cnt   = DWELL_LD;
      end else begin
        w_done = 1'b1;
        if (continuous && w_low_hit) begin
          w_state = SCAN;
          w_code  = w_low;
          w_valid = 1'b1;
          w_cnt   = DWELL_LD;
        end else begin
          w_state = IDLE;
          w_valid = 1'b0;
          w_cnt   = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_code  <= w_code;
      r_valid <= w_valid;
      r_done  <= w_done;
    end
  end

  assign code       = r_code;
  assign code_valid = r_valid;
  assign frame_done = r_done;
  assign busy       = (r_state != IDLE);

endmodule
